// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: pipelined multiply, radix-2 restoring divide.
// Optional: define MD_DIV_EARLY_EXIT_EN to finish divides with |dividend| < |divisor| in one cycle.
module muldiv_ctrl #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [7:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        op_ready,
    output logic        busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Handshake: a request transfers on a rising edge where op_valid & op_ready
    // and op is one-hot; the requester holds op/src_a/src_b stable until then.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [5:0] MUL_LOAD  = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_ITERS = 6'd32;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] op_a;      // raw rs operand (multiplicand, or dividend for div-by-zero / early exit)
    logic [31:0] op_b;      // multiplier, or divisor magnitude
    logic [31:0] quo;
    logic [31:0] rem;
    logic        mul_signed;
    logic        neg_quo;
    logic        neg_rem;

    logic        op_onehot;
    logic        accept;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] trial;
    logic        take;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign busy      = (state != IDLE);
    assign op_ready  = (state == IDLE) & ~cancel;
    assign op_onehot = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    assign accept    = op_valid & op_ready & op_onehot;

    // Signed divide works on magnitudes; signs are restored in the fixup cycle.
    assign a_mag = (op[5] && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag = (op[5] && src_b[31]) ? (32'd0 - src_b) : src_b;

    assign ext_a   = mul_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
    assign ext_b   = mul_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
    assign product = ext_a * ext_b;

    assign shifted  = {rem, quo[31]};
    assign trial    = shifted - {1'b0, op_b};
    assign take     = (shifted >= {1'b0, op_b});
    assign rem_next = take ? trial[31:0] : shifted[31:0];
    assign quo_next = {quo[30:0], take};

    assign quo_fix = neg_quo ? (32'd0 - quo) : quo;
    assign rem_fix = neg_rem ? (32'd0 - rem) : rem;

`ifdef MD_DIV_EARLY_EXIT_EN
    logic early_exit;
    assign early_exit = (count == DIV_ITERS) && (op_b != 32'd0) && (quo < op_b);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 6'd0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            rd_valid   <= 1'b0;
            rd_data    <= 32'd0;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            mul_signed <= 1'b0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= src_a;
                        if (op[7] || op[6]) begin
                            op_b       <= src_b;
                            mul_signed <= op[7];
                            count      <= MUL_LOAD;
                            state      <= MUL;
                        end else if (op[5] || op[4]) begin
                            quo     <= a_mag;
                            op_b    <= b_mag;
                            rem     <= 32'd0;
                            neg_quo <= op[5] & (src_a[31] ^ src_b[31]);
                            neg_rem <= op[5] & src_a[31];
                            count   <= DIV_ITERS;
                            state   <= DIV;
                        end else if (op[3]) begin
                            hi <= src_a;
                        end else if (op[2]) begin
                            lo <= src_a;
                        end else if (op[1]) begin
                            rd_data  <= hi;
                            rd_valid <= 1'b1;
                        end else begin
                            rd_data  <= lo;
                            rd_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (cancel) begin
                        count <= 6'd0;
                        state <= IDLE;
                    end else if (count == 6'd0) begin
                        hi    <= product[63:32];
                        lo    <= product[31:0];
                        state <= IDLE;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                DIV: begin
                    if (cancel) begin
                        count <= 6'd0;
                        state <= IDLE;
`ifdef MD_DIV_EARLY_EXIT_EN
                    end else if (early_exit) begin
                        hi    <= op_a;
                        lo    <= 32'd0;
                        count <= 6'd0;
                        state <= IDLE;
`endif
                    end else if (count != 6'd0) begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - 6'd1;
                    end else begin
                        // Divide by zero reports all-ones quotient and the untouched dividend.
                        if (op_b == 32'd0) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= op_a;
                        end else begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed test-plan cases plus random traffic against an arithmetic model.
module tb_muldiv_ctrl;

    localparam int MUL_LATENCY = 2;

    localparam logic [7:0] OP_MULT  = 8'h80;
    localparam logic [7:0] OP_MULTU = 8'h40;
    localparam logic [7:0] OP_DIV   = 8'h20;
    localparam logic [7:0] OP_DIVU  = 8'h10;
    localparam logic [7:0] OP_MTHI  = 8'h08;
    localparam logic [7:0] OP_MTLO  = 8'h04;
    localparam logic [7:0] OP_MFHI  = 8'h02;
    localparam logic [7:0] OP_MFLO  = 8'h01;

`ifdef MD_DIV_EARLY_EXIT_EN
    localparam int EARLY_EN = 1;
`else
    localparam int EARLY_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [7:0]  op = 8'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        cancel = 1'b0;
    logic        op_ready;
    logic        busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic checking = 1'b0;

    muldiv_ctrl #(.MUL_LATENCY(MUL_LATENCY)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .op_ready (op_ready),
        .busy     (busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .hi       (hi),
        .lo       (lo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_left = 0;          // busy cycles still to run
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;
    logic        m_rd_valid = 1'b0;
    logic [31:0] exp_q[$];

    function automatic void ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] p_hi, output logic [31:0] p_lo);
        logic [63:0] p;
        if (sgn) p = 64'(longint'($signed(a)) * longint'($signed(b)));
        else     p = {32'd0, a} * {32'd0, b};
        p_hi = p[63:32];
        p_lo = p[31:0];
    endfunction

    function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int cyc);
        longint sa, sb, ma, mb;
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        cyc = 33;
        if (EARLY_EN != 0 && b != 32'd0 && ma < mb) cyc = 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_rd_valid = 1'b0;
            exp_q.delete();
        end else begin
            m_rd_valid = 1'b0;
            if (m_left > 0) begin
                if (cancel) m_left = 0;
                else if (m_left == 1) begin
                    m_hi = m_pend_hi;
                    m_lo = m_pend_lo;
                    m_left = 0;
                end else m_left = m_left - 1;
            end else if (op_valid && !cancel && $countones(op) == 1) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        ref_mul(op == OP_MULT, src_a, src_b, m_pend_hi, m_pend_lo);
                        m_left = MUL_LATENCY;
                    end
                    OP_DIV, OP_DIVU: ref_div(op == OP_DIV, src_a, src_b, m_pend_lo, m_pend_hi, m_left);
                    OP_MTHI: m_hi = src_a;
                    OP_MTLO: m_lo = src_a;
                    OP_MFHI: begin exp_q.push_back(m_hi); m_rd_valid = 1'b1; end
                    default: begin exp_q.push_back(m_lo); m_rd_valid = 1'b1; end
                endcase
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("busy", 32'(busy), 32'(m_left > 0));
            check("op_ready", 32'(op_ready), 32'((m_left == 0) && !cancel));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            if (m_rd_valid && exp_q.size() > 0) check("rd_data", rd_data, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request, waits for acceptance, then counts busy cycles.
    // Returns at the falling edge after busy drops.
    task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc);
        int w;
        op_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 100) begin
            step();
            @(negedge clk);
            w++;
        end
        check("accept", 32'(op_ready), 32'd1);
        step();
        op_valid = 1'b0;
        op = 8'd0;
        busy_cyc = 0;
        @(negedge clk);
        while (busy && busy_cyc < 100) begin
            busy_cyc++;
            step();
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        int w;
        step();
        checking = 1'b1;
        step();
        @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        reset = 1'b0;
        step();

        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, cyc);
        check("mult_cycles", 32'(cyc), 32'(MUL_LATENCY));
        check("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", lo, 32'hFFFF_FFFE);
        step();

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, cyc);
        check("multu_hi_lit", hi, 32'h1);
        check("multu_lo_lit", lo, 32'hFFFF_FFFE);
        step();

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h2, cyc);
        check("div_cycles", 32'(cyc), 32'd33);
        check("div_lo_lit", lo, 32'hFFFF_FFFD);
        check("div_hi_lit", hi, 32'hFFFF_FFFF);
        step();

        run_op(OP_DIVU, 32'h7, 32'h2, cyc);
        check("divu_lo_lit", lo, 32'h3);
        check("divu_hi_lit", hi, 32'h1);
        step();

        run_op(OP_DIVU, 32'h5, 32'h0, cyc);
        check("divz_cycles", 32'(cyc), 32'd33);
        check("divz_lo_lit", lo, 32'hFFFF_FFFF);
        check("divz_hi_lit", hi, 32'h5);
        step();

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("ovf_lo_lit", lo, 32'h8000_0000);
        check("ovf_hi_lit", hi, 32'h0);
        step();

        // mfhi held behind an in-flight divide
        op_valid = 1'b1; op = OP_DIV; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        step();
        op = OP_MFHI;
        w = 0;
        @(negedge clk);
        while (!op_ready && w < 100) begin
            w++;
            step();
            @(negedge clk);
        end
        check("mfhi_stall_cycles", 32'(w), 32'd33);
        step();
        op_valid = 1'b0; op = 8'd0;
        @(negedge clk);
        check("mfhi_rd_valid_lit", 32'(rd_valid), 32'd1);
        check("mfhi_rd_data_lit", rd_data, 32'd2);
        step();

        // cancel part-way through a divide
        run_op(OP_MTHI, 32'h1234, 32'h0, cyc);
        step();
        run_op(OP_MTLO, 32'h5678, 32'h0, cyc);
        step();
        op_valid = 1'b1; op = OP_DIV; src_a = 32'd9; src_b = 32'd4;
        step();
        op_valid = 1'b0; op = 8'd0;
        for (int i = 1; i < 10; i++) step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_hi_lit", hi, 32'h1234);
        check("cancel_lo_lit", lo, 32'h5678);
        step();

        // cancel in IDLE blocks the accept
        op_valid = 1'b1; op = OP_MTHI; src_a = 32'hDEAD; cancel = 1'b1;
        step();
        cancel = 1'b0; op_valid = 1'b0; op = 8'd0;
        @(negedge clk);
        check("idle_cancel_hi", hi, 32'h1234);
        step();

        // zero-hot and multi-hot requests are ignored
        op_valid = 1'b1; op = 8'h00; src_a = 32'hBEEF;
        @(negedge clk);
        check("zero_hot_ready", 32'(op_ready), 32'd1);
        step();
        op = 8'h88;
        step();
        op_valid = 1'b0; op = 8'd0;
        @(negedge clk);
        check("multi_hot_hi", hi, 32'h1234);
        check("multi_hot_busy", 32'(busy), 32'd0);
        step();

        // reset in the middle of a multiply
        op_valid = 1'b1; op = OP_MULT; src_a = 32'd3; src_b = 32'd5;
        step();
        op_valid = 1'b0; op = 8'd0; reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mul_hi", hi, 32'd0);
        check("rst_mul_lo", lo, 32'd0);
        check("rst_mul_busy", 32'(busy), 32'd0);
        check("rst_mul_ready", 32'(op_ready), 32'd1);
        step();

        run_op(OP_DIVU, 32'd3, 32'd10, cyc);
        check("small_div_cycles", 32'(cyc), (EARLY_EN != 0) ? 32'd1 : 32'd33);
        check("small_div_lo_lit", lo, 32'd0);
        check("small_div_hi_lit", hi, 32'd3);
        step();

        // random traffic
        for (int c = 0; c < 6000; c++) begin
            op_valid = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) == 0) op = 8'($urandom_range(0, 255));
            else op = 8'(1 << $urandom_range(0, 7));
            src_a = rand_operand();
            src_b = rand_operand();
            cancel = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 999) == 0);
            step();
        end
        op_valid = 1'b0; op = 8'd0; cancel = 1'b0; reset = 1'b0;
        for (int i = 0; i < 40; i++) step();
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd0);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
